us_capture_sequencer: RTL and testbench
=======================================

// Module: us_capture_sequencer
// PURPOSE
// - Sequences ultrasound ADC capture into a 32-bit Avalon-MM read slave for the HPS/Nios host.
// - Arm by register write, wait for transmit trigger, buffer N samples in a FIFO, raise irq when done.
// - Host drains samples through a pop-on-read data register; single-clock, sits beside the PIO slaves.
// PARAMETERS
// - DATA_W      14    ADC sample width, zero-extended to 32 on readout (1..32)
// - FIFO_DEPTH  1024  sample buffer depth, power of 2, >= 4
// - CNT_W       16    width of sample-count register and remaining counter
// PORTS
// - clk        in   1       system clock; all logic on rising edge
// - reset_n    in   1       asynchronous active-low reset
// - address    in   2       Avalon word address: 0 DATA, 1 STATUS, 2 CTRL, 3 NSAMP
// - read       in   1       Avalon read strobe, one cycle per access
// - write      in   1       Avalon write strobe
// - writedata  in   32      Avalon write data
// - readdata   out  32      registered read data, latency 1
// - trig_in    in   1       transmit trigger, synchronous to clk, rising-edge sensitive
// - adc_data   in   DATA_W  ADC sample
// - adc_valid  in   1       adc_data qualifier, one sample per high cycle
// - irq        out  1       capture-done interrupt, level
// - busy       out  1       high in ARMED or CAPTURE
// BEHAVIOUR
// - Reset: readdata=0, irq=0, busy=0, state IDLE, FIFO empty, NSAMP=0, sticky flags 0, trig edge reg 0.
// - readdata <= mux(address) every cycle read=1; holds otherwise. DATA read with FIFO non-empty returns head
//   and pops it; empty returns 0 and sets underflow. STATUS: [1:0] state, [2] overflow, [3] underflow,
//   [4] empty, [5] full, [6] irq, [CNT_W+15:16] FIFO level. CTRL reads 0. NSAMP reads back [CNT_W-1:0].
// - CTRL write bits: [0] start, [1] abort, [2] sw_trig, [3] irq_clear. Bits self-clear; no storage.
// - FSM IDLE(0) ARMED(1) CAPTURE(2) DONE(3):
//   IDLE/DONE + start & NSAMP!=0 -> ARMED; remaining<=NSAMP, clears irq/overflow/underflow; FIFO NOT flushed.
//   start with NSAMP==0, or in ARMED/CAPTURE: ignored.
//   ARMED + (trig_in rising edge | sw_trig) -> CAPTURE; samples accepted from the following cycle.
//   CAPTURE: each adc_valid decrements remaining and pushes sample if not full; if full, sample dropped,
//   overflow set, remaining still decrements (capture window fixed in samples-time).
//   CAPTURE + adc_valid & remaining==1 -> DONE, irq<=1 same edge.
//   DONE: irq held until irq_clear or start. abort from any state -> IDLE next edge, FIFO flushed, irq cleared.
// - Simultaneous push and pop: both occur, level unchanged, order preserved; pop at full frees slot same edge
//   so push succeeds. abort same cycle as pop/push: abort wins, FIFO empty next cycle.
// - NSAMP write during ARMED/CAPTURE updates register only; active capture uses latched remaining.
// - Read and write same cycle allowed; write to CTRL and DATA pop act independently.
// - adc_valid outside CAPTURE ignored. Level counter width log2(FIFO_DEPTH)+1; pointers wrap modulo depth.
// - Reset mid-capture: immediate asynchronous return to reset values; no partial data retained.
// STRUCTURE
// - Package us_capture_pkg: register address localparams, CTRL bit positions, STATUS field positions,
//   FSM state enum (2-bit encoding above).
// - Sub-module us_capture_fifo: synchronous single-clock FIFO (push, pop, flush, dout=head, level, full,
//   empty); show-ahead so head is valid when !empty. Top holds FSM, counters, register mux, irq.
// TESTING
// - NSAMP=4, start, trig_in pulse, adc_valid x4 with 1,2,3,4 -> state DONE, irq=1; 4 DATA reads return
//   0x1,0x2,0x3,0x4; STATUS empty=1, level 0.
// - FIFO_DEPTH=8, NSAMP=10, 10 samples -> level 8, full=1, overflow=1, irq=1; reads return samples 1..8.
// - DATA read when empty -> readdata 0, underflow=1; next start clears underflow.
// - abort after 2 of 6 samples -> IDLE next cycle, busy=0, empty=1, irq=0; later adc_valid ignored.
// - Level 3, push and DATA pop same cycle -> level stays 3, read returns oldest, order preserved.
// - start with NSAMP=0 -> stays IDLE; reset_n low during CAPTURE -> all outputs reset without clock edge.

Source files
------------

// File: rtl/us_capture_pkg.sv
// us_capture_pkg
// Shared definitions for the ultrasound capture sequencer. It holds the
// Avalon register map, the CTRL command bit positions, the STATUS field
// positions and the sequencer state encoding. The state values are visible
// to the host through STATUS[1:0], so their encoding is fixed.
package us_capture_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_NSAMP  = 2'd3;

  // CTRL write command bits. They act as one-shot commands and are not stored.
  localparam int CTRL_START     = 0;
  localparam int CTRL_ABORT     = 1;
  localparam int CTRL_SW_TRIG   = 2;
  localparam int CTRL_IRQ_CLEAR = 3;

  // STATUS read fields
  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_UNDERFLOW = 3;
  localparam int STAT_EMPTY     = 4;
  localparam int STAT_FULL      = 5;
  localparam int STAT_IRQ       = 6;
  localparam int STAT_LEVEL_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/us_capture_fifo.sv
// us_capture_fifo
// Single-clock show-ahead sample FIFO. dout always shows the head entry, and
// that entry is valid whenever empty is low.
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   push, din         write request and write data
//   pop               read request; the head advances on the clock edge
//   flush             empties the FIFO and takes priority over push and pop
//   dout              head entry
//   level             number of stored entries (0..DEPTH)
//   full, empty       level == DEPTH, level == 0
// A pop while full frees a slot on the same edge, so a simultaneous push is
// accepted. A push while full without a pop is dropped.
module us_capture_fifo #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [AW:0]       level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              push_fire, pop_fire;

  assign full      = (level_q == (AW+1)'(DEPTH));
  assign empty     = (level_q == '0);
  assign pop_fire  = pop & ~empty & ~flush;
  assign push_fire = push & ~flush & (~full | pop_fire);

  assign dout  = mem[rd_ptr_q];
  assign level = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // The pointers wrap naturally because DEPTH is a power of two.
      if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the sample storage has no reset. The pointers and the level define
  // which entries are valid, so stale contents are never observed, and leaving
  // reset off lets the array map onto block RAM.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/us_capture_sequencer.sv
// us_capture_sequencer
// Sequences ultrasound ADC capture behind a 32-bit Avalon-MM slave.
// The host arms the sequencer through CTRL. A transmit trigger, either the
// rising edge of trig_in or the sw_trig command, starts the capture. NSAMP
// ADC samples are then buffered in the FIFO, and irq is raised when the
// capture window ends. The host drains samples by reading DATA, which pops
// the FIFO.
// Ports:
//   clk, reset_n                  clock and asynchronous active-low reset
//   address, read, write,         Avalon slave; readdata is registered and
//   writedata, readdata           appears with a latency of 1 cycle
//   trig_in                       transmit trigger (rising-edge sensitive)
//   adc_data, adc_valid           ADC sample stream
//   irq                           capture-done interrupt (level)
//   busy                          high while ARMED or CAPTURE
module us_capture_sequencer
  import us_capture_pkg::*;
#(
  parameter int DATA_W     = 14,
  parameter int FIFO_DEPTH = 1024,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              trig_in,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic              irq,
  output logic              busy
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  nsamp_q, nsamp_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              irq_q, irq_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              trig_q;

  logic              ctrl_wr, cmd_start, cmd_abort, cmd_sw_trig, cmd_irq_clear;
  logic              data_rd, trig_rise, sample_evt, start_ok, sample_drop;
  logic [31:0]       status_w;

  logic [DATA_W-1:0] fifo_dout;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full, fifo_empty, fifo_pop;

  // Only CNT_W bits of writedata carry state. The upper bits are ignored.
  if (CNT_W < 32) begin : g_wdata_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:CNT_W];
  end

  assign ctrl_wr       = write & (address == ADDR_CTRL);
  assign cmd_start     = ctrl_wr & writedata[CTRL_START];
  assign cmd_abort     = ctrl_wr & writedata[CTRL_ABORT];
  assign cmd_sw_trig   = ctrl_wr & writedata[CTRL_SW_TRIG];
  assign cmd_irq_clear = ctrl_wr & writedata[CTRL_IRQ_CLEAR];

  assign data_rd    = read & (address == ADDR_DATA);
  assign fifo_pop   = data_rd & ~fifo_empty;
  assign trig_rise  = trig_in & ~trig_q;
  assign sample_evt = (state_q == ST_CAPTURE) & adc_valid;
  // A DATA pop on the same edge frees a slot, so that sample is not dropped.
  assign sample_drop = sample_evt & fifo_full & ~fifo_pop;
  assign start_ok    = cmd_start & (nsamp_q != '0) &
                       ((state_q == ST_IDLE) | (state_q == ST_DONE));

  us_capture_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (sample_evt),
    .pop     (fifo_pop),
    .flush   (cmd_abort),
    .din     (adc_data),
    .dout    (fifo_dout),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    status_w                                = '0;
    status_w[STAT_STATE_LSB +: 2]           = state_q;
    status_w[STAT_OVERFLOW]                 = ovf_q;
    status_w[STAT_UNDERFLOW]                = udf_q;
    status_w[STAT_EMPTY]                    = fifo_empty;
    status_w[STAT_FULL]                     = fifo_full;
    status_w[STAT_IRQ]                      = irq_q;
    status_w[STAT_LEVEL_LSB +: LVL_W]       = fifo_level;
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    state_d     = state_q;
    remaining_d = remaining_q;
    nsamp_d     = nsamp_q;
    readdata_d  = readdata_q;
    irq_d       = irq_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;

    if (read) begin
      unique case (address)
        ADDR_DATA:   readdata_d = fifo_empty ? '0 : 32'(fifo_dout);
        ADDR_STATUS: readdata_d = status_w;
        ADDR_CTRL:   readdata_d = '0;
        ADDR_NSAMP:  readdata_d = 32'(nsamp_q);
        default:     readdata_d = '0;
      endcase
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d     = ST_ARMED;
          remaining_d = nsamp_q;
          irq_d       = 1'b0;
          ovf_d       = 1'b0;
          udf_d       = 1'b0;
        end
      end
      ST_ARMED: begin
        if (trig_rise | cmd_sw_trig) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // The window counts samples in time, so dropped samples still count.
        if (adc_valid) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (sample_drop)            ovf_d = 1'b1;
    if (data_rd && fifo_empty)  udf_d = 1'b1;

    // A clear request loses against a completion on the same edge.
    if (cmd_irq_clear) irq_d = 1'b0;
    if (sample_evt && remaining_q == CNT_W'(1)) irq_d = 1'b1;

    if (cmd_abort) begin
      state_d = ST_IDLE;
      irq_d   = 1'b0;
    end

    if (write && address == ADDR_NSAMP) nsamp_d = writedata[CNT_W-1:0];
  end

  assign busy_d = (state_d == ST_ARMED) | (state_d == ST_CAPTURE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      nsamp_q     <= '0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      trig_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      nsamp_q     <= nsamp_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      trig_q      <= trig_in;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_us_capture_sequencer.sv
// Testbench for us_capture_sequencer. A transaction-level model (a sample
// queue plus a few integers) predicts readdata, irq and busy after every
// clock edge. Directed scenarios pin the model with literal values, and
// randomized traffic follows them.
module tb_us_capture_sequencer;

  localparam int DATA_W = 14;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        address = '0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              trig_in = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic              irq, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  us_capture_sequencer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .trig_in   (trig_in),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .irq       (irq),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state;      // 0 idle, 1 armed, 2 capture, 3 done
  int          m_rem;
  int          m_nsamp;
  bit          m_irq, m_ovf, m_udf, m_trig_prev;
  int          m_q[$];
  logic [31:0] m_rd;

  function automatic void model_reset();
    m_state = 0; m_rem = 0; m_nsamp = 0;
    m_irq = 0; m_ovf = 0; m_udf = 0; m_trig_prev = 0;
    m_q.delete();
    m_rd = '0;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[1:0]   = 2'(m_state);
    s[2]     = m_ovf;
    s[3]     = m_udf;
    s[4]     = (m_q.size() == 0);
    s[5]     = (m_q.size() == DEPTH);
    s[6]     = m_irq;
    s[31:16] = 16'(m_q.size());
    return s;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    bit ctrl_wr, start, abort, sw, iclr, rise, udf_set, done;
    ctrl_wr = write && (address == 2'd2);
    start   = ctrl_wr && writedata[0];
    abort   = ctrl_wr && writedata[1];
    sw      = ctrl_wr && writedata[2];
    iclr    = ctrl_wr && writedata[3];
    rise    = trig_in && !m_trig_prev;
    m_trig_prev = trig_in;
    udf_set = 0;
    done    = 0;

    if (read) begin
      case (address)
        2'd0: begin
          if (m_q.size() > 0) m_rd = 32'(m_q.pop_front());
          else begin m_rd = '0; udf_set = 1; end
        end
        2'd1: m_rd = model_status();
        2'd2: m_rd = '0;
        default: m_rd = 32'(m_nsamp);
      endcase
    end

    case (m_state)
      0, 3: if (start && m_nsamp != 0) begin
        m_state = 1; m_rem = m_nsamp; m_irq = 0; m_ovf = 0; m_udf = 0;
      end
      1: if (rise || sw) m_state = 2;
      default: if (adc_valid) begin
        if (m_q.size() < DEPTH) m_q.push_back(int'(adc_data));
        else m_ovf = 1;
        m_rem--;
        if (m_rem == 0) begin m_state = 3; done = 1; end
      end
    endcase

    if (udf_set) m_udf = 1;
    if (iclr) m_irq = 0;
    if (done) m_irq = 1;
    if (abort) begin
      m_state = 0; m_irq = 0; m_q.delete();
    end
    if (write && address == 2'd3) m_nsamp = int'(writedata[CNT_W-1:0]);
  endfunction

  // One clock: step the model, then compare all outputs 1 time unit after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("readdata", readdata, m_rd);
    check("irq", 32'(irq), 32'(m_irq));
    check("busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; write = 1'b1; writedata = d;
    cycle();
    write = 1'b0; writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a; read = 1'b1;
    cycle();
    read = 1'b0;
  endtask

  task automatic sample(input int v);
    adc_valid = 1'b1; adc_data = DATA_W'(v);
    cycle();
    adc_valid = 1'b0; adc_data = '0;
  endtask

  task automatic pulse_trig();
    trig_in = 1'b1;
    cycle();
    trig_in = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    #10 reset_n = 1'b1;
    cycle();

    // Basic capture of four samples.
    wr(2'd3, 32'd4);
    wr(2'd2, 32'h1);
    check("armed_busy", 32'(busy), 32'h1);
    pulse_trig();
    for (int i = 1; i <= 4; i++) sample(i);
    check("done_irq", 32'(irq), 32'h1);
    rd(2'd1);
    check("status_done4", readdata, 32'h0004_0043);
    for (int i = 1; i <= 4; i++) begin
      rd(2'd0);
      check("drain4", readdata, 32'(i));
    end
    rd(2'd1);
    check("status_empty", readdata, 32'h0000_0053);

    // A DATA read on an empty FIFO returns 0 and sets underflow.
    rd(2'd0);
    check("underflow_data", readdata, 32'h0);
    rd(2'd1);
    check("status_underflow", readdata, 32'h0000_005B);
    wr(2'd2, 32'h8);
    check("irq_clear", 32'(irq), 32'h0);

    // Overflow: ten samples into an eight-entry FIFO. Start also clears underflow.
    wr(2'd3, 32'd10);
    wr(2'd2, 32'h1);
    rd(2'd1);
    check("start_clears_udf", readdata, 32'h0000_0011);
    pulse_trig();
    for (int i = 1; i <= 10; i++) sample(i);
    rd(2'd1);
    check("status_overflow", readdata, 32'h0008_0067);
    for (int i = 1; i <= 8; i++) begin
      rd(2'd0);
      check("drain8", readdata, 32'(i));
    end

    // Push and pop on the same cycle at level 3.
    wr(2'd3, 32'd6);
    wr(2'd2, 32'h1);
    wr(2'd2, 32'h4);
    sample(32'h11); sample(32'h12); sample(32'h13);
    adc_valid = 1'b1; adc_data = 14'h14; address = 2'd0; read = 1'b1;
    cycle();
    adc_valid = 1'b0; read = 1'b0;
    check("pushpop_oldest", readdata, 32'h11);
    rd(2'd1);
    check("pushpop_level", readdata, 32'h0003_0002);
    for (int i = 0; i < 3; i++) begin
      rd(2'd0);
      check("pushpop_order", readdata, 32'h12 + 32'(i));
    end
    wr(2'd2, 32'h2);

    // Abort after 2 of 6 samples.
    wr(2'd2, 32'h1);
    pulse_trig();
    sample(1); sample(2);
    wr(2'd2, 32'h2);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_irq", 32'(irq), 32'h0);
    sample(5); sample(6);
    rd(2'd1);
    check("abort_status", readdata, 32'h0000_0010);

    // A start with NSAMP=0 is ignored.
    wr(2'd3, 32'd0);
    wr(2'd2, 32'h1);
    check("nsamp0_busy", 32'(busy), 32'h0);
    rd(2'd1);
    check("nsamp0_status", readdata, 32'h0000_0010);

    // Asynchronous reset in the middle of a capture.
    wr(2'd3, 32'd5);
    wr(2'd2, 32'h1);
    pulse_trig();
    sample(7); sample(8);
    rd(2'd1);
    check("pre_reset_status", readdata, 32'h0002_0002);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    model_reset();
    #3 reset_n = 1'b1;
    cycle();
    rd(2'd1);
    check("post_reset_status", readdata, 32'h0000_0010);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      read      = ($urandom % 4) == 0;
      write     = ($urandom % 5) == 0;
      address   = 2'($urandom % 4);
      writedata = $urandom;
      if (address == 2'd2) begin
        writedata    = '0;
        writedata[0] = ($urandom % 3) == 0;
        writedata[1] = ($urandom % 16) == 0;
        writedata[2] = ($urandom % 4) == 0;
        writedata[3] = ($urandom % 4) == 0;
      end else if (address == 2'd3) begin
        writedata = $urandom % 13;
      end
      adc_valid = 1'($urandom % 2);
      adc_data  = DATA_W'($urandom);
      trig_in   = ($urandom % 6) == 0;
      cycle();
    end
    read = 1'b0; write = 1'b0; adc_valid = 1'b0; trig_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
